// File: rtl/stamofu_reg_read_if.sv
// Interface between the stamofu issue queue, the writeback bus / PRF read
// ports, the stamofu register-read stage and the stamofu address stage.
// The master modport is the environment around the stage; the slave modport
// is the register-read stage itself.
interface stamofu_reg_read_if #(
  parameter int PRF_BANK_COUNT         = 4,
  parameter int LOG_PRF_BANK_COUNT     = 2,
  parameter int LOG_STAMOFU_CQ_ENTRIES = 4,
  parameter int XLEN                   = 32
);
  // issue side
  logic                              issue_valid;
  logic                              issue_is_store;
  logic                              issue_is_amo;
  logic                              issue_is_fence;
  logic [3:0]                        issue_op;
  logic [11:0]                       issue_imm12;
  logic                              issue_A_forward;
  logic                              issue_A_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]     issue_A_bank;
  logic                              issue_B_forward;
  logic                              issue_B_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]     issue_B_bank;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] issue_cq_index;
  logic                              pipeline_ready;

  // operand sources
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0] WB_bus_data_by_bank;
  logic                                A_reg_read_ack;
  logic [XLEN-1:0]                     A_reg_read_data;
  logic                                B_reg_read_ack;
  logic [XLEN-1:0]                     B_reg_read_data;

  // address-stage side
  logic                              out_valid;
  logic                              out_is_store;
  logic                              out_is_amo;
  logic                              out_is_fence;
  logic [3:0]                        out_op;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] out_cq_index;
  logic [XLEN-1:0]                   out_addr;
  logic [XLEN-1:0]                   out_wdata;
  logic                              out_ready;

  modport master (
    output issue_valid, issue_is_store, issue_is_amo, issue_is_fence, issue_op,
           issue_imm12, issue_A_forward, issue_A_is_zero, issue_A_bank,
           issue_B_forward, issue_B_is_zero, issue_B_bank, issue_cq_index,
           WB_bus_data_by_bank, A_reg_read_ack, A_reg_read_data,
           B_reg_read_ack, B_reg_read_data, out_ready,
    input  pipeline_ready, out_valid, out_is_store, out_is_amo, out_is_fence,
           out_op, out_cq_index, out_addr, out_wdata
  );

  modport slave (
    input  issue_valid, issue_is_store, issue_is_amo, issue_is_fence, issue_op,
           issue_imm12, issue_A_forward, issue_A_is_zero, issue_A_bank,
           issue_B_forward, issue_B_is_zero, issue_B_bank, issue_cq_index,
           WB_bus_data_by_bank, A_reg_read_ack, A_reg_read_data,
           B_reg_read_ack, B_reg_read_data, out_ready,
    output pipeline_ready, out_valid, out_is_store, out_is_amo, out_is_fence,
           out_op, out_cq_index, out_addr, out_wdata
  );
endinterface

// File: rtl/stamofu_reg_read.sv
// Stamofu register-read stage. One operand-collect (OC) slot gathers the base
// (A) and store data (B) from x0, a one-shot WB-bus forward or a PRF read
// ack; once both are present and the output register is free, the op
// launches into the OUT register with its effective address computed.
module stamofu_reg_read #(
  parameter int PRF_BANK_COUNT         = 4,
  parameter int LOG_PRF_BANK_COUNT     = 2,
  parameter int LOG_STAMOFU_CQ_ENTRIES = 4,
  parameter int XLEN                   = 32
) (
  input logic               CLK,
  input logic               nRST,
  stamofu_reg_read_if.slave bus
);

  typedef enum logic {OC_IDLE, OC_COLLECT} oc_state_t;

  // per-operand collect state
  typedef struct packed {
    logic                          forward;
    logic [LOG_PRF_BANK_COUNT-1:0] bank;
    logic                          saved;
    logic [XLEN-1:0]               data;
  } operand_t;

  // operand-collect register
  oc_state_t                         oc_state;
  logic                              oc_first;
  logic                              oc_is_store;
  logic                              oc_is_amo;
  logic                              oc_is_fence;
  logic [3:0]                        oc_op;
  logic [11:0]                       oc_imm12;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] oc_cq_index;
  operand_t                          oc_A;
  operand_t                          oc_B;

  // output register
  logic                              out_valid_q;
  logic                              out_is_store_q;
  logic                              out_is_amo_q;
  logic                              out_is_fence_q;
  logic [3:0]                        out_op_q;
  logic [LOG_STAMOFU_CQ_ENTRIES-1:0] out_cq_index_q;
  logic [XLEN-1:0]                   out_addr_q;
  logic [XLEN-1:0]                   out_wdata_q;

  logic [PRF_BANK_COUNT-1:0][XLEN-1:0] wb_data;
  logic                                oc_valid;
  logic                                A_satisfied;
  logic                                B_satisfied;
  logic [XLEN-1:0]                     A_value;
  logic [XLEN-1:0]                     B_value;
  logic                                launch;
  logic                                ready;
  logic                                accept;

  assign wb_data = bus.WB_bus_data_by_bank;

  // Returns {satisfied, value}. A saved operand (x0 or earlier hit) wins;
  // otherwise a first-cycle forward beats a same-cycle PRF ack.
  function automatic logic [XLEN:0] resolve(
    input operand_t        opnd,
    input logic            first,
    input logic            ack,
    input logic [XLEN-1:0] ack_data,
    input logic [XLEN-1:0] fwd_data
  );
    logic [XLEN:0] result;
    result = {opnd.saved, opnd.data};
    if (!opnd.saved) begin
      if (first && opnd.forward) result = {1'b1, fwd_data};
      else if (ack)              result = {1'b1, ack_data};
    end
    return result;
  endfunction

  // Operand resolution, launch decision and issue backpressure.
  always_comb begin
    // NOTE: every signal here is assigned on every pass through the block, so no path can leave one holding its old value (which would infer a latch).
    oc_valid                  = (oc_state == OC_COLLECT);
    {A_satisfied, A_value}    = resolve(oc_A, oc_first, bus.A_reg_read_ack,
                                        bus.A_reg_read_data, wb_data[oc_A.bank]);
    {B_satisfied, B_value}    = resolve(oc_B, oc_first, bus.B_reg_read_ack,
                                        bus.B_reg_read_data, wb_data[oc_B.bank]);
    launch = oc_valid & A_satisfied & B_satisfied & (~out_valid_q | bus.out_ready);
    ready  = ~oc_valid | launch;
    accept = bus.issue_valid & ready;
  end

  assign bus.pipeline_ready = ready;

  // OC slot: capture on accept, free on launch, otherwise keep collecting.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oc_state    <= OC_IDLE;
      oc_first    <= 1'b0;
      oc_is_store <= 1'b0;
      oc_is_amo   <= 1'b0;
      oc_is_fence <= 1'b0;
      oc_op       <= '0;
      oc_imm12    <= '0;
      oc_cq_index <= '0;
      // NOTE: the saved operand data is reset along with its flags; it is only a couple of words and keeps X out of the launch mux.
      oc_A        <= '0;
      oc_B        <= '0;
    end else if (accept) begin
      oc_state     <= OC_COLLECT;
      oc_first     <= 1'b1;
      oc_is_store  <= bus.issue_is_store;
      oc_is_amo    <= bus.issue_is_amo;
      oc_is_fence  <= bus.issue_is_fence;
      oc_op        <= bus.issue_op;
      oc_imm12     <= bus.issue_imm12;
      oc_cq_index  <= bus.issue_cq_index;
      oc_A.forward <= bus.issue_A_forward;
      oc_A.bank    <= bus.issue_A_bank;
      oc_A.saved   <= bus.issue_A_is_zero;
      oc_A.data    <= '0;
      oc_B.forward <= bus.issue_B_forward;
      oc_B.bank    <= bus.issue_B_bank;
      oc_B.saved   <= bus.issue_B_is_zero;
      oc_B.data    <= '0;
    end else if (launch) begin
      oc_state <= OC_IDLE;
      oc_first <= 1'b0;
    end else if (oc_valid) begin
      oc_first   <= 1'b0;
      oc_A.saved <= A_satisfied;
      oc_A.data  <= A_value;
      oc_B.saved <= B_satisfied;
      oc_B.data  <= B_value;
    end
  end

  // OUT register: load on launch, hold until the address stage takes it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid_q    <= 1'b0;
      out_is_store_q <= 1'b0;
      out_is_amo_q   <= 1'b0;
      out_is_fence_q <= 1'b0;
      out_op_q       <= '0;
      out_cq_index_q <= '0;
      out_addr_q     <= '0;
      out_wdata_q    <= '0;
    end else if (launch) begin
      out_valid_q    <= 1'b1;
      out_is_store_q <= oc_is_store;
      out_is_amo_q   <= oc_is_amo;
      out_is_fence_q <= oc_is_fence;
      out_op_q       <= oc_op;
      out_cq_index_q <= oc_cq_index;
      out_addr_q     <= A_value + {{(XLEN-12){oc_imm12[11]}}, oc_imm12};
      out_wdata_q    <= B_value;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_is_store = out_is_store_q;
  assign bus.out_is_amo   = out_is_amo_q;
  assign bus.out_is_fence = out_is_fence_q;
  assign bus.out_op       = out_op_q;
  assign bus.out_cq_index = out_cq_index_q;
  assign bus.out_addr     = out_addr_q;
  assign bus.out_wdata    = out_wdata_q;

endmodule
